// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg
// Shared processor package for the pipeline hazard logic.
// Holds the hazard FSM state encoding, the default memory-wait timeout and
// small saturating-increment helpers used by the hazard unit and its
// optional performance counters.
// ---------------------------------------------------------------------------
package hazard_unit_pkg;

  // RUN is the normal flowing pipeline; MEM_WAIT holds everything while a
  // data access in MEM is outstanding.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazardState_t;

  // Default number of MEM_WAIT cycles before mem_timeout is flagged.
  localparam int DEFAULT_TIMEOUT = 255;

  // Saturating +1 for the 8-bit memory wait counter.
  function automatic logic [7:0] satInc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // Saturating +1 for the 16-bit performance counters.
  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// ---------------------------------------------------------------------------
// hazard_perf_counters
// Three 16-bit saturating event counters for the hazard unit. Only
// instantiated when HAZARD_PERF_CNT_EN is defined.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset (clears all counters)
//   stallEvent   one data-hazard bubble inserted this cycle
//   flushEvent   one branch flush performed this cycle
//   freezeEvent  pipeline frozen this cycle
//   stall_cnt    number of data-hazard bubbles
//   flush_cnt    number of branch flushes
//   freeze_cnt   number of freeze cycles
// ---------------------------------------------------------------------------
module hazard_perf_counters
  import hazard_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stallEvent,
  input  logic        flushEvent,
  input  logic        freezeEvent,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
);

  // Each counter advances by one per qualifying cycle and sticks at its
  // maximum rather than wrapping, so a long run never reads back as small.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      freeze_cnt <= '0;
    end else begin
      if (stallEvent)  stall_cnt  <= satInc16(stall_cnt);
      if (flushEvent)  flush_cnt  <= satInc16(flush_cnt);
      if (freezeEvent) freeze_cnt <= satInc16(freeze_cnt);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard control: load-use style data-hazard stalls, taken-branch
// flushes and a whole-pipeline freeze while a memory access is outstanding.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the stall_cnt, flush_cnt
// and freeze_cnt performance counter outputs (hazard_perf_counters).
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   IF_ID_R1/R2       source registers of the instruction in ID
//   IF_ID_UsesR2      ID instruction actually reads R2
//   ID_EX_Rd          destination register of the instruction in EX
//   ID_EX_RegWrite    EX instruction writes ID_EX_Rd
//   EX_BranchTaken    branch/jump resolved taken in EX
//   EX_MEM_MemAccess  data access in MEM
//   mem_ready         memory completes the access this cycle
//   PC_Write          allow PC update
//   IF_ID_Write       allow IF/ID register update
//   IF_ID_Flush       squash IF/ID contents
//   ID_EX_Flush       squash ID/EX contents (insert bubble)
//   pipe_freeze       hold the entire pipeline
//   mem_timeout       sticky flag: memory wait reached TIMEOUT cycles
//   stall_cnt/flush_cnt/freeze_cnt  (HAZARD_PERF_CNT_EN only)
// Parameter:
//   TIMEOUT           MEM_WAIT cycles before mem_timeout is raised
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] IF_ID_R1,
  input  logic [4:0] IF_ID_R2,
  input  logic       IF_ID_UsesR2,
  input  logic [4:0] ID_EX_Rd,
  input  logic       ID_EX_RegWrite,
  input  logic       EX_BranchTaken,
  input  logic       EX_MEM_MemAccess,
  input  logic       mem_ready,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Flush,
  output logic       pipe_freeze,
  output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [15:0] freeze_cnt
`endif
);

  localparam logic [31:0] TIMEOUT_U = TIMEOUT;

  hazardState_t state;
  logic [7:0]   waitCnt;
  logic [7:0]   waitCntInc;
  logic         dataHazard;
  logic         freezeNow;

  // A hazard exists only when EX will write a real register that ID reads.
  // Forwarding only covers MEM/WB, so a distance-1 dependency must bubble.
  always_comb begin
    dataHazard = ID_EX_RegWrite && (ID_EX_Rd != 5'd0) &&
                 ((ID_EX_Rd == IF_ID_R1) ||
                  (IF_ID_UsesR2 && (ID_EX_Rd == IF_ID_R2)));
  end

  // Freeze starts combinationally in the very RUN cycle where the access
  // stalls, and ends in the MEM_WAIT cycle where mem_ready arrives.
  always_comb begin
    if (state == RUN) begin
      freezeNow = EX_MEM_MemAccess && !mem_ready;
    end else begin
      freezeNow = !mem_ready;
    end
  end

  // Output priority: reset, then freeze, then branch, then data hazard.
  // Reset is applied here as well so the outputs hold their reset values
  // for as long as rst is low, independent of the other inputs.
  always_comb begin
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!rst) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (freezeNow) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_freeze = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (dataHazard) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  assign waitCntInc = satInc8(waitCnt);

  // Memory wait FSM. The counter restarts at 0 on every entry to MEM_WAIT
  // and counts every MEM_WAIT cycle; the timeout flag is sticky and does
  // not force an exit, the FSM still waits for mem_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      waitCnt     <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (EX_MEM_MemAccess && !mem_ready) begin
            state   <= MEM_WAIT;
            waitCnt <= 8'd0;
          end
        end
        MEM_WAIT: begin
          waitCnt <= waitCntInc;
          if ({24'd0, waitCntInc} >= TIMEOUT_U) begin
            mem_timeout <= 1'b1;
          end
          if (mem_ready) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stallEvent;
  logic flushEvent;

  // Count only the actions actually taken, after priority resolution.
  assign stallEvent = !freezeNow && !EX_BranchTaken && dataHazard;
  assign flushEvent = !freezeNow && EX_BranchTaken;

  hazard_perf_counters perfCounters (
    .clk         (clk),
    .rst         (rst),
    .stallEvent  (stallEvent),
    .flushEvent  (flushEvent),
    .freezeEvent (freezeNow),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt),
    .freeze_cnt  (freeze_cnt)
  );
`endif

endmodule
